log2_share_arb: RTL

//  Round-robin arbiter and sequencer that shares one log2_cal unit (16-bit Q3.13 in, 4-bit signed out)

---
 rtl/log2_share_arb.sv | 134 +++++++++++++
 1 files changed

// File: rtl/log2_share_arb.sv
// Round-robin arbiter that time-shares one log2_cal unit between N_REQ requesters,
// one transaction in flight at a time, returning id-tagged results on a valid/ready port.
module log2_share_arb #(
  parameter int N_REQ = 4,
  parameter int DW    = 16,
  parameter int IDW   = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [N_REQ*DW-1:0] req_data,
  output logic [N_REQ-1:0]   req_ready,
  output logic               l2_en,
  output logic [DW-1:0]      l2_v_in,
  input  logic [3:0]         l2_v_out,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [IDW-1:0]     rsp_id,
  output logic [3:0]         rsp_data,
  output logic               rsp_err,
  output logic               busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    CAPT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t          state_r;
  logic [IDW-1:0]  rr_ptr_r;
  logic [IDW-1:0]  id_r;
  logic            zero_r;

  logic            found_s;
  logic [IDW-1:0]  grant_id_s;
  logic [IDW-1:0]  next_ptr_s;
  logic [DW-1:0]   sel_data_s;
  int              idx_v;

  // Round-robin search from rr_ptr for the first valid requester
  always_comb begin
    found_s    = 1'b0;
    grant_id_s = '0;
    idx_v      = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx_v = (int'(rr_ptr_r) + k) % N_REQ;
      if (!found_s && ((req_valid & (N_REQ'(1) << idx_v)) != '0)) begin
        found_s    = 1'b1;
        grant_id_s = IDW'(idx_v);
      end else begin
        found_s    = found_s;
      end
    end
  end

  // Grant decode, selected sample and pointer advance
  always_comb begin
    sel_data_s = DW'(req_data >> (int'(grant_id_s) * DW));
    if (int'(grant_id_s) == N_REQ - 1) begin
      next_ptr_s = '0;
    end else begin
      next_ptr_s = grant_id_s + IDW'(1);
    end
    // Reset is folded in so no grant is visible while the block is held in reset
    if (!rst && (state_r == IDLE) && found_s) begin
      req_ready = N_REQ'(1) << grant_id_s;
    end else begin
      req_ready = '0;
    end
  end

  // Transaction sequencer with registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      rr_ptr_r  <= '0;
      id_r      <= '0;
      zero_r    <= 1'b0;
      l2_en     <= 1'b0;
      l2_v_in   <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= 4'd0;
      rsp_err   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (found_s) begin
            l2_v_in  <= sel_data_s;
            id_r     <= grant_id_s;
            zero_r   <= (sel_data_s == '0);
            rr_ptr_r <= next_ptr_s;
            l2_en    <= 1'b1;
            busy     <= 1'b1;
            state_r  <= ISSUE;
          end else begin
            state_r  <= IDLE;
          end
        end
        ISSUE: begin
          l2_en   <= 1'b0;
          state_r <= CAPT;
        end
        CAPT: begin
          // log2_cal leaves its output untouched for zero, so the stale value is masked
          rsp_data  <= zero_r ? 4'd0 : l2_v_out;
          rsp_err   <= zero_r;
          rsp_id    <= id_r;
          rsp_valid <= 1'b1;
          state_r   <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            state_r   <= IDLE;
          end else begin
            state_r   <= RESP;
          end
        end
        default: begin
          l2_en     <= 1'b0;
          rsp_valid <= 1'b0;
          busy      <= 1'b0;
          state_r   <= IDLE;
        end
      endcase
    end
  end

endmodule
